// File: rtl/snake_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Constants shared by the snake game controller and the movement stage:
//               game state codes, direction codes and screen limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

  // Game state codes. Codes 6 and 7 are unused.
  typedef enum logic [2:0] {
    STATE_START_INTERFACE = 3'd0,
    STATE_CHOOSE_LEVEL    = 3'd1,
    STATE_IDLE            = 3'd2,
    STATE_PLAY            = 3'd3,
    STATE_PAUSE           = 3'd4,
    STATE_WIN_INTERFACE   = 3'd5
  } game_state_e;

  // Snake heading codes used by the movement stage.
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  // Visible screen size in pixels.
  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;

  // Level rotation on the selection screen: right 1->2->3->1, left 1->3->2->1.
  // Any out-of-range value recovers to level 1.
  function automatic logic [1:0] next_level(input logic [1:0] lvl, input logic go_right);
    logic [1:0] nxt;
    nxt = 2'd1;
    if (go_right) begin
      case (lvl)
        2'd1:    nxt = 2'd2;
        2'd2:    nxt = 2'd3;
        default: nxt = 2'd1;
      endcase
    end else begin
      case (lvl)
        2'd1:    nxt = 2'd3;
        2'd3:    nxt = 2'd2;
        default: nxt = 2'd1;
      endcase
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_score_counter.sv
// ============================================================================
// Module      : bcd_score_counter
// Description : Two-digit BCD score counter with synchronous clear and a
//               saturating increment (stops at 99).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_score_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       inc_i,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o
);

  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       at_max;

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

  // Score digits: clear has priority, increment carries units into tens and holds at 99.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else if (clear_i) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else if (inc_i && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_q <= 4'd0;
        tens_q <= tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// Module      : game_ctrl
// Description : Snake game sequencer. Menu/level selection, idle preview,
//               play/pause/win flow, level speed and BCD score.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_ctrl
  import snake_pkg::*;
#(
  parameter int          WIN_SCORE = 20,
  parameter int          IDLE_HOLD = 25_000_000,
  parameter logic [27:0] SPEED_L1  = 28'd25_000_000,
  parameter logic [27:0] SPEED_L2  = 28'd12_500_000,
  parameter logic [27:0] SPEED_L3  = 28'd6_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_enter,
  input  logic        key_pause,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        target_ate,
  input  logic        lost,
  output logic [2:0]  game_state,
  output logic [1:0]  level_sel,
  output logic [27:0] mov_speed,
  output logic [3:0]  score_count0,
  output logic [3:0]  score_count1
);

  localparam int               IDLE_W    = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_HOLD - 1);
  // A WIN_SCORE above 99 yields a tens digit no BCD score can reach, disabling the win.
  localparam logic [3:0]       WIN_TENS  = 4'(WIN_SCORE / 10);
  localparam logic [3:0]       WIN_ONES  = 4'(WIN_SCORE % 10);

  game_state_e       state_q;
  logic [1:0]        level_q;
  logic [27:0]       speed_q;
  logic [IDLE_W-1:0] idle_cnt_q;

  logic enter_q, pause_q, left_q, right_q, ate_q;
  logic ev_enter, ev_pause, ev_left, ev_right, ev_ate;
  logic score_clear, score_inc, score_win;
  logic [3:0] ones, tens;

  assign ev_enter = key_enter  & ~enter_q;
  assign ev_pause = key_pause  & ~pause_q;
  assign ev_left  = key_left   & ~left_q;
  assign ev_right = key_right  & ~right_q;
  assign ev_ate   = target_ate & ~ate_q;

  // Key and target_ate history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      enter_q <= 1'b0;
      pause_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      ate_q   <= 1'b0;
    end else begin
      enter_q <= key_enter;
      pause_q <= key_pause;
      left_q  <= key_left;
      right_q <= key_right;
      ate_q   <= target_ate;
    end
  end

  assign score_clear = (state_q == STATE_IDLE);
  // An eat edge in PLAY still scores even when lost arrives in the same cycle.
  assign score_inc   = (state_q == STATE_PLAY) && ev_ate;
  assign score_win   = (tens == WIN_TENS) && (ones == WIN_ONES);

  // Game flow, level selection and idle preview counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= STATE_START_INTERFACE;
      level_q    <= 2'd1;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        STATE_START_INTERFACE: begin
          if (ev_enter) state_q <= STATE_CHOOSE_LEVEL;
        end
        STATE_CHOOSE_LEVEL: begin
          // Enter beats a simultaneous arrow so the level is locked as shown.
          if (ev_enter)      state_q <= STATE_IDLE;
          else if (ev_right) level_q <= next_level(level_q, 1'b1);
          else if (ev_left)  level_q <= next_level(level_q, 1'b0);
        end
        STATE_IDLE: begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_q    <= STATE_PLAY;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        STATE_PLAY: begin
          if (lost)           state_q <= STATE_START_INTERFACE;
          else if (score_win) state_q <= STATE_WIN_INTERFACE;
          else if (ev_pause)  state_q <= STATE_PAUSE;
        end
        STATE_PAUSE: begin
          if (ev_pause) state_q <= STATE_PLAY;
        end
        STATE_WIN_INTERFACE: begin
          if (ev_enter) state_q <= STATE_START_INTERFACE;
        end
        default: state_q <= STATE_START_INTERFACE;
      endcase
    end
  end

  // Move period for the selected level, one cycle behind level_sel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      speed_q <= SPEED_L1;
    end else begin
      case (level_q)
        2'd2:    speed_q <= SPEED_L2;
        2'd3:    speed_q <= SPEED_L3;
        default: speed_q <= SPEED_L1;
      endcase
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .rst     (rst),
    .clear_i (score_clear),
    .inc_i   (score_inc),
    .ones_o  (ones),
    .tens_o  (tens)
  );

  assign game_state   = state_q;
  assign level_sel    = level_q;
  assign mov_speed    = speed_q;
  assign score_count0 = ones;
  assign score_count1 = tens;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// Module      : tb_game_ctrl
// Description : Directed scoreboard bench for game_ctrl. A second instance with
//               an unreachable win score exercises score saturation at 99.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_enter = 1'b0, key_pause = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic target_ate = 1'b0, lost = 1'b0;

  logic [2:0]  g1_state, g2_state;
  logic [1:0]  g1_level, g2_level;
  logic [27:0] g1_speed, g2_speed;
  logic [3:0]  g1_s0, g1_s1, g2_s0, g2_s1;

  always #5 clk = ~clk;

  game_ctrl #(.WIN_SCORE(20), .IDLE_HOLD(10)) dut (
    .clk(clk), .rst(rst), .key_enter(key_enter), .key_pause(key_pause),
    .key_left(key_left), .key_right(key_right), .target_ate(target_ate), .lost(lost),
    .game_state(g1_state), .level_sel(g1_level), .mov_speed(g1_speed),
    .score_count0(g1_s0), .score_count1(g1_s1)
  );

  game_ctrl #(.WIN_SCORE(100), .IDLE_HOLD(10)) dut_sat (
    .clk(clk), .rst(rst), .key_enter(key_enter), .key_pause(key_pause),
    .key_left(key_left), .key_right(key_right), .target_ate(target_ate), .lost(lost),
    .game_state(g2_state), .level_sel(g2_level), .mov_speed(g2_speed),
    .score_count0(g2_s0), .score_count1(g2_s1)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  lv;
    logic [27:0] sp;
    logic [7:0]  sc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Bench model of the main instance.
  int e_state  = 0;
  int e_level  = 1;
  int lvl_prev = 1;
  int e_score  = 0;

  function automatic logic [27:0] speed_of(input int l);
    case (l)
      2:       return 28'd12_500_000;
      3:       return 28'd6_250_000;
      default: return 28'd25_000_000;
    endcase
  endfunction

  function automatic logic [7:0] bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the main instance's outputs.
  task automatic compare_top();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check1({t, ".state"}, 32'(g1_state), 32'(e.st));
    check1({t, ".level"}, 32'(g1_level), 32'(e.lv));
    check1({t, ".speed"}, 32'(g1_speed), 32'(e.sp));
    check1({t, ".score"}, 32'({g1_s1, g1_s0}), 32'(e.sc));
  endtask

  // Push the expected post-edge outputs, clock once, then compare.
  task automatic step(input string tag);
    exp_t e;
    e.st = 3'(e_state);
    e.lv = 2'(e_level);
    e.sp = speed_of(lvl_prev);
    e.sc = bcd(e_score);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    tick();
    compare_top();
    lvl_prev = e_level;
  endtask

  // One target_ate pulse, 3 cycles high and 1 low.
  task automatic pulse(input string tag);
    target_ate = 1'b1;
    if (e_state == 3 && e_score < 99) e_score++;
    step(tag);
    step(tag);
    step(tag);
    target_ate = 1'b0;
    step(tag);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    tick();
    step("reset");
    rst = 1'b1;

    // Enter held 50 cycles yields a single event
    key_enter = 1'b1;
    e_state = 1;
    step("enter_start");
    repeat (49) step("enter_held");
    key_enter = 1'b0;
    step("enter_release");

    // Level rotation
    key_right = 1'b1; e_level = 2; step("right_1to2");
    key_right = 1'b0; step("right_rel");
    key_right = 1'b1; e_level = 3; step("right_2to3");
    key_right = 1'b0; step("right_rel");
    key_right = 1'b1; e_level = 1; step("right_3to1");
    key_right = 1'b0; step("right_rel");
    key_left  = 1'b1; e_level = 3; step("left_1to3");
    key_left  = 1'b0; step("left_rel");

    // Enter with a simultaneous arrow: enter wins, level stays 3
    key_enter = 1'b1; key_right = 1'b1;
    e_state = 2;
    step("enter_beats_right");
    key_enter = 1'b0; key_right = 1'b0;
    repeat (9) step("idle_hold");
    e_state = 3;
    step("play_entry");

    // 12 pulses in PLAY
    for (int i = 0; i < 12; i++) pulse("play_pulse");

    // Pause, ignored lost and target_ate, resume
    key_pause = 1'b1; e_state = 4; step("pause_on");
    key_pause = 1'b0; step("pause_rel");
    lost = 1'b1; step("lost_in_pause");
    lost = 1'b0;
    pulse("pulse_in_pause");
    pulse("pulse_in_pause");
    key_pause = 1'b1; e_state = 3; step("pause_off");
    key_pause = 1'b0; step("pause_off_rel");

    // Reach WIN_SCORE: win is seen the cycle after the score hits 20
    for (int i = 0; i < 7; i++) pulse("play_pulse2");
    target_ate = 1'b1;
    e_score = 20;
    step("score_20");
    e_state = 5;
    step("win");
    step("win_hold");
    target_ate = 1'b0;
    step("win_hold");
    key_enter = 1'b1; e_state = 0; step("win_to_start");
    key_enter = 1'b0; step("start_score_kept");

    // Back to PLAY; IDLE clears the kept score
    key_enter = 1'b1; e_state = 1; step("menu2");
    key_enter = 1'b0; step("menu2_rel");
    key_enter = 1'b1; e_state = 2; step("idle2_entry");
    key_enter = 1'b0;
    e_score = 0;
    repeat (9) step("idle2_hold");
    e_state = 3;
    step("play2_entry");
    for (int i = 0; i < 3; i++) pulse("play2_pulse");

    // lost together with an eat edge: score still increments
    target_ate = 1'b1; lost = 1'b1;
    e_score = 4; e_state = 0;
    step("lost_with_inc");
    target_ate = 1'b0; lost = 1'b0;
    step("lost_after");

    // Saturation on the instance whose win score is unreachable
    key_enter = 1'b1; tick(); key_enter = 1'b0; tick();
    key_enter = 1'b1; tick(); key_enter = 1'b0;
    repeat (10) tick();
    check1("sat_play_entry", 32'(g2_state), 32'd3);
    check1("sat_cleared", 32'({g2_s1, g2_s0}), 32'h00);
    repeat (99) begin
      target_ate = 1'b1; tick();
      target_ate = 1'b0; tick();
    end
    check1("sat_99", 32'({g2_s1, g2_s0}), 32'h99);
    target_ate = 1'b1; tick();
    target_ate = 1'b0; tick();
    check1("sat_hold_99", 32'({g2_s1, g2_s0}), 32'h99);
    check1("sat_state_play", 32'(g2_state), 32'd3);
    check1("sat_main_won", 32'(g1_state), 32'd5);
    check1("sat_main_score", 32'({g1_s1, g1_s0}), 32'h20);

    // Reset mid-PLAY
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check1("rst_mid.state", 32'(g2_state), 32'd0);
    check1("rst_mid.level", 32'(g2_level), 32'd1);
    check1("rst_mid.speed", 32'(g2_speed), 32'd25_000_000);
    check1("rst_mid.score", 32'({g2_s1, g2_s0}), 32'h00);
    check1("rst_win.state", 32'(g1_state), 32'd0);
    check1("rst_win.score", 32'({g1_s1, g1_s0}), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
